// File: rtl/mig_tt_sweeper.sv
// rtl/mig_tt_sweeper.sv - majority-inverter graph truth-table sweeper; optional MIG_EVAL_PIPE_EN adds an eval/capture pipe stage
module mig_tt_sweeper #(
    parameter int N_IN    = 7,
    parameter int N_GATES = 6,
    localparam int SW     = $clog2(1 + N_IN + N_GATES),
    localparam int OPW    = SW + 1,
    localparam int AW     = $clog2(N_GATES + 1),
    localparam int TTW    = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [3*OPW-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [TTW-1:0]   tt,
    output logic             tt_valid,
    output logic [N_IN:0]    ones
);

    localparam logic [AW-1:0] ADDR_OUT = AW'(N_GATES);
    localparam logic [N_IN:0] M_LAST   = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
`ifdef MIG_EVAL_PIPE_EN
        S_DRAIN,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3*OPW-1:0] prog [N_GATES];
    logic [OPW-1:0]   out_op;
    logic [N_IN:0]    m_q;
    logic [N_IN-1:0]  x;
    logic             f;
    logic             cfg_ok;
    logic             sweep_start;

`ifdef MIG_EVAL_PIPE_EN
    logic             cap_vld;
    logic             cap_bit;
    logic [N_IN-1:0]  cap_idx;
`endif

    // Operand value for a consumer at position k; only gates j<k are visible,
    // so self/forward references and out-of-range selects collapse to const 0.
    function automatic logic operand(input logic [OPW-1:0] op,
                                     input logic [N_IN-1:0] xv,
                                     input logic [N_GATES-1:0] wv,
                                     input int k);
        int   s;
        logic v;
        s = int'(op[SW-1:0]);
        v = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (s == i + 1) v = xv[i];
        end
        for (int j = 0; j < N_GATES; j++) begin
            if (s == N_IN + 1 + j && j < k) v = wv[j];
        end
        return v ^ op[OPW-1];
    endfunction

    assign x = m_q[N_IN-1:0];

    always_comb begin
        logic [N_GATES-1:0] w;
        logic a, b, c;
        w = '0;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        for (int k = 0; k < N_GATES; k++) begin
            a = operand(prog[k][OPW-1:0],       x, w, k);
            b = operand(prog[k][2*OPW-1:OPW],   x, w, k);
            c = operand(prog[k][3*OPW-1:2*OPW], x, w, k);
            w[k] = (a & b) | (a & c) | (b & c);
        end
        f = operand(out_op, x, w, N_GATES);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWEEP;
            S_SWEEP: begin
                if (m_q == M_LAST) begin
`ifdef MIG_EVAL_PIPE_EN
                    state_d = S_DRAIN;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MIG_EVAL_PIPE_EN
            S_DRAIN: state_d = S_DONE;
`endif
            S_DONE:  state_d = start ? S_SWEEP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign cfg_ok      = (state_q == S_IDLE || state_q == S_DONE) && (cfg_addr <= ADDR_OUT);
    assign sweep_start = (state_q != S_SWEEP) && (state_d == S_SWEEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_GATES; k++) prog[k] <= '0;
            out_op   <= '0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= '0;
            tt_valid <= 1'b0;
            ones     <= '0;
            m_q      <= '0;
`ifdef MIG_EVAL_PIPE_EN
            cap_vld  <= 1'b0;
            cap_bit  <= 1'b0;
            cap_idx  <= '0;
`endif
        end else begin
            if (cfg_we && cfg_ok) begin
                if (cfg_addr == ADDR_OUT) out_op <= cfg_data[OPW-1:0];
                else                      prog[cfg_addr] <= cfg_data;
            end
            cfg_err <= cfg_we && !cfg_ok;
            done    <= (state_d == S_DONE);
`ifdef MIG_EVAL_PIPE_EN
            busy    <= (state_d == S_SWEEP) || (state_d == S_DRAIN);
`else
            busy    <= (state_d == S_SWEEP);
`endif
            if (state_d == S_DONE) tt_valid <= 1'b1;

`ifdef MIG_EVAL_PIPE_EN
            // Stage 1 evaluates minterm m; stage 2 commits it one cycle later.
            cap_vld <= (state_q == S_SWEEP);
            if (state_q == S_SWEEP) begin
                cap_bit <= f;
                cap_idx <= x;
                m_q     <= m_q + 1'b1;
            end
            if (cap_vld) begin
                tt[cap_idx] <= cap_bit;
                ones        <= ones + {{N_IN{1'b0}}, cap_bit};
            end
`else
            if (state_q == S_SWEEP) begin
                tt[x] <= f;
                ones  <= ones + {{N_IN{1'b0}}, f};
                m_q   <= m_q + 1'b1;
            end
`endif
            if (sweep_start) begin
                tt_valid <= 1'b0;
                m_q      <= '0;
                ones     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// tb/tb_mig_tt_sweeper.sv - directed bench for mig_tt_sweeper (N_IN=7, N_GATES=6)
module tb_mig_tt_sweeper;

    localparam int N_IN = 7;
    localparam int N_GATES = 6;
`ifdef MIG_EVAL_PIPE_EN
    localparam int LAT = 130;
`else
    localparam int LAT = 129;
`endif
    localparam logic [127:0] EX_TT  = 128'hFEEAEAAAEEE8E888EEE8E888AAA8A880;
    localparam logic [127:0] FWD_TT = {32{4'h8}};
    localparam logic [127:0] ALL1   = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [14:0]  cfg_data;
    logic         cfg_err;
    logic         start;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic         tt_valid;
    logic [7:0]   ones;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mig_tt_sweeper #(.N_IN(N_IN), .N_GATES(N_GATES)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .start(start), .busy(busy),
        .done(done), .tt(tt), .tt_valid(tt_valid), .ones(ones)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] op(input int sel, input logic inv);
        return {inv, 4'(sel)};
    endfunction

    function automatic logic [14:0] gate(input int a, input int b, input int c);
        return {op(c, 1'b0), op(b, 1'b0), op(a, 1'b0)};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [14:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_example();
        wr(3'd0, gate(2, 6, 7));
        wr(3'd1, gate(2, 4, 5));
        wr(3'd2, gate(2, 3, 4));
        wr(3'd3, gate(1, 8, 9));
        wr(3'd4, gate(3, 5, 10));
        wr(3'd5, gate(1, 11, 12));
        wr(3'd6, {10'b0, op(13, 1'b0)});
    endtask

    // Caller has already raised start (#1 after an edge); counts edges until done.
    task automatic wait_done(output int n, output logic b1, output logic v1);
        n = 0;
        b1 = 1'b0;
        v1 = 1'b1;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (n == 1) begin
                b1 = busy;
                v1 = tt_valid;
            end
            if (done) break;
        end
    endtask

    int   n;
    logic b1, v1;
    int   first, dcount;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_valid", 128'(tt_valid), 128'd0);
        check("rst_tt", tt, 128'd0);
        check("rst_ones", 128'(ones), 128'd0);
        check("rst_err", 128'(cfg_err), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // constant output, inverted
        wr(3'd6, {10'b0, op(0, 1'b1)});
        check("inv_err", 128'(cfg_err), 128'd0);
        start = 1'b1;
        wait_done(n, b1, v1);
        check("inv_lat", 128'(n), 128'(LAT));
        check("inv_tt", tt, ALL1);
        check("inv_ones", 128'(ones), 128'd128);
        check("inv_valid", 128'(tt_valid), 128'd1);

        // example majority network
        load_example();
        start = 1'b1;
        wait_done(n, b1, v1);
        check("ex_lat", 128'(n), 128'(LAT));
        check("ex_busy", 128'(b1), 128'd1);
        check("ex_valid0", 128'(v1), 128'd0);
        check("ex_tt", tt, EX_TT);
        check("ex_ones", 128'(ones), 128'd64);
        check("ex_idle", 128'(busy), 128'd0);

        // back-to-back: start in the done cycle
        start = 1'b1;
        wait_done(n, b1, v1);
        check("b2b_busy", 128'(b1), 128'd1);
        check("b2b_valid", 128'(v1), 128'd0);
        check("b2b_lat", 128'(n), 128'(LAT));
        check("b2b_tt", tt, EX_TT);
        @(posedge clk);
        #1;
        check("done_pulse", 128'(done), 128'd0);
        check("hold_valid", 128'(tt_valid), 128'd1);

        // forward reference reads const 0
        wr(3'd0, gate(1, 11, 2));
        wr(3'd6, {10'b0, op(8, 1'b0)});
        start = 1'b1;
        wait_done(n, b1, v1);
        check("fwd_tt", tt, FWD_TT);
        check("fwd_ones", 128'(ones), 128'd32);

        // bad address
        wr(3'd7, gate(1, 1, 1));
        check("bad_addr_err", 128'(cfg_err), 128'd1);
        @(posedge clk);
        #1;
        check("bad_addr_clr", 128'(cfg_err), 128'd0);

        // write and start during sweep are rejected/ignored
        start = 1'b1;
        first = 0;
        dcount = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cfg_we = 1'b0;
            if (done) begin
                dcount++;
                if (first == 0) first = k;
            end
            if (k == 10) begin
                cfg_we = 1'b1;
                cfg_addr = 3'd6;
                cfg_data = {10'b0, op(3, 1'b0)};
            end
            if (k == 11) begin
                check("busy_wr_err", 128'(cfg_err), 128'd1);
                start = 1'b1;
            end
            if (k == 12) check("busy_wr_pulse", 128'(cfg_err), 128'd0);
        end
        check("rej_lat", 128'(first), 128'(LAT));
        check("rej_once", 128'(dcount), 128'd1);
        check("rej_tt", tt, FWD_TT);
        check("rej_ones", 128'(ones), 128'd32);

        // reset mid-sweep at minterm 60
        start = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_tt", tt, 128'd0);
        check("mid_rst_valid", 128'(tt_valid), 128'd0);
        check("mid_rst_ones", 128'(ones), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_example();
        start = 1'b1;
        wait_done(n, b1, v1);
        check("re_lat", 128'(n), 128'(LAT));
        check("re_tt", tt, EX_TT);
        check("re_ones", 128'(ones), 128'd64);
        check("re_valid", 128'(tt_valid), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
